bcd_decade_display: RTL
=======================

Name: bcd_decade_display

Overview:
- Downstream consumer of the 4-bit mod-10 ripple counter output. Samples the counter's asynchronous q bus into the system clock domain and filters ripple/clear transients.
- Extends the count with DIGITS-1 further synchronous BCD decades, clocked by detected 9->0 wraps.
- Drives a time-multiplexed 7-segment display plus a parallel BCD value bus.

Parameters:
- DIGITS, 3, total decimal digits: units from the ripple counter plus DIGITS-1 internal decades; legal range 2..8.
- SCAN_DIV, 1024, clk cycles each digit is displayed; must be >= 2.
- STABLE_CYC, 2, consecutive identical synchronized samples required before accepting a units value; must be >= 1.

Ports:
- clk  input  1  system clock; all state is on its rising edge.
- clr  input  1  asynchronous active-low reset.
- cnt_in  input  4  units digit from the mod-10 ripple counter q bus; asynchronous to clk and may glitch.
- value  output  4*DIGITS  BCD count; units in [3:0], next decade in [7:4], and so on.
- carry  output  1  one-cycle pulse on each accepted 9->0 units wrap.
- overflow  output  1  sticky; set when every digit wraps to 0.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high.
- an  output  DIGITS  one-hot digit enable, active-high; bit i selects digit i.

Behaviour:
- Reset (clr=0, asynchronous, any cycle):
  - sync flops, stability counter, value, carry, overflow, prescaler and scan index all 0.
  - an = 1 (digit 0); seg = 7'h3F (glyph "0").
  - Release is synchronous to the next clk edge.
- Synchronizer: two-flop chain s1 -> s2 on cnt_in; no logic between the flops.
- Stability filter:
  - Counter stab increments while s2 equals its previous-cycle value and saturates at STABLE_CYC. Any change reloads stab to 0.
  - A candidate is accepted on the cycle where stab reaches STABLE_CYC and s2 <= 9. Values 10..15 (the transient clear state) are never accepted; units holds.
  - Latency: a cnt_in change stable before edge k appears in value[3:0] by edge k+2+STABLE_CYC.
- Wrap detect, on acceptance of new units n with previous units p:
  - p=9 and n=0: assert carry for exactly one cycle, concurrent with the units update.
  - Any other change, including a non-9 -> 0 clear from upstream: update units only, no carry.
  - Re-accepting an equal value: no effect.
- Upper decades: on carry, digit 1 increments.
  - A digit at 9 wraps to 0 and increments the next digit in the same cycle (synchronous ripple, no extra latency).
  - If all upper digits are 9 on a carry, they become 0 and overflow sets. overflow clears only by clr.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At terminal count it returns to 0 and the scan index advances (DIGITS-1 -> 0).
  - an and seg are registered and update on the same edge as the index.
  - seg is the glyph of the selected digit's current value, re-evaluated every cycle, so a value change shows without waiting for a scan step.
  - Glyphs: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Codes >9 cannot occur.
- Simultaneous events:
  - A carry while digit i is being displayed: seg shows the post-increment value one cycle later.
  - clr asserted mid-scan or mid-filter: all state aborts to reset values immediately.

Test Plan:
- Reset: clr=0 mid-run with value=0x347 -> value=0, carry=0, overflow=0, an=001, seg=3F asynchronously; after release, first scan step after SCAN_DIV cycles -> an=010.
- Count sequence: drive cnt_in 0..9,0, each held 10 cycles (DIGITS=3) -> units track with latency 2+STABLE_CYC; one carry pulse at the 9->0; value=0x010.
- Glitch rejection: hold 9, insert 1 cycle of 4'hA, then 0 -> no acceptance of A, exactly one carry; 1-cycle spike to 5 with STABLE_CYC=2 -> units unchanged.
- Non-wrap clear: units 6 -> 0 -> no carry; upper digits unchanged.
- Ripple/overflow: value=0x999, drive 9->0 wrap -> value=0x000, carry=1 for one cycle, overflow=1 and stays 1 through further counting until clr.
- Scan/decode: value=0x852, SCAN_DIV=4 -> every 4 cycles an steps 001->010->100->001 with seg 5B, 6D, 7F respectively.

Source files
------------

// File: rtl/bcd_decade_display.sv
// Purpose: filters the async ripple-counter units digit, extends it with DIGITS-1 BCD decades, drives a scanned 7-seg display.
// Latency: cnt_in change -> value[3:0] in 2+STABLE_CYC clk edges; seg/an registered, one cycle behind value.
// Backpressure: none; free-running consumer that samples cnt_in every cycle and never stalls.
module bcd_decade_display #(
   parameter int DIGITS     = 3,
   parameter int SCAN_DIV   = 1024,
   parameter int STABLE_CYC = 2
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic [3:0]            cnt_in,
   output logic [4*DIGITS-1:0]   value,
   output logic                  carry,
   output logic                  overflow,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an
);

   localparam int IDX_W  = $clog2(DIGITS);
   localparam int PRE_W  = $clog2(SCAN_DIV);
   localparam int STAB_W = $clog2(STABLE_CYC + 1);

   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC);
   localparam logic [PRE_W-1:0]  PRE_TC   = PRE_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

   // Segment glyphs {g,f,e,d,c,b,a}; codes above 9 never reach here.
   function automatic logic [6:0] f_glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'h3F;
         4'd1:    g = 7'h06;
         4'd2:    g = 7'h5B;
         4'd3:    g = 7'h4F;
         4'd4:    g = 7'h66;
         4'd5:    g = 7'h6D;
         4'd6:    g = 7'h7D;
         4'd7:    g = 7'h07;
         4'd8:    g = 7'h7F;
         4'd9:    g = 7'h6F;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

   logic [3:0]            r_s1;
   logic [3:0]            r_s2;
   logic [3:0]            r_s2_prev;
   logic [STAB_W-1:0]     r_stab;
   logic [4*DIGITS-1:0]   r_value;
   logic                  r_carry;
   logic                  r_ovf;
   logic [PRE_W-1:0]      r_pre;
   logic [IDX_W-1:0]      r_idx;
   logic [DIGITS-1:0]     r_an;
   logic [6:0]            r_seg;

   logic [STAB_W-1:0]     w_stab_nxt;
   logic                  w_accept;
   logic [4*DIGITS-1:0]   w_value_nxt;
   logic                  w_carry_nxt;
   logic                  w_ovf_set;
   logic                  w_chain;
   logic                  w_pre_tc;
   logic [IDX_W-1:0]      w_idx_nxt;
   logic [DIGITS-1:0]     w_an_nxt;
   logic [3:0]            w_digit_sel;

   // Two-flop synchronizer plus a copy of last cycle's s2 for the stability compare.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_s1      <= 4'd0;
         r_s2      <= 4'd0;
         r_s2_prev <= 4'd0;
      end else begin
         r_s1      <= cnt_in;
         r_s2      <= r_s1;
         r_s2_prev <= r_s2;
      end
   end

   // Stability count: reload on any change, saturate once the sample has settled long enough.
   always_comb begin
      if (r_s2 != r_s2_prev) begin
         w_stab_nxt = '0;
      end else if (r_stab == STAB_MAX) begin
         w_stab_nxt = r_stab;
      end else begin
         w_stab_nxt = r_stab + STAB_W'(1);
      end
   end

   // A settled BCD sample that differs from the held units digit is taken; 10..15 are clear transients.
   assign w_accept = (w_stab_nxt == STAB_MAX) && (r_s2 <= 4'd9) && (r_s2 != r_value[3:0]);

   // Units update plus single-cycle ripple through the upper decades on a 9->0 wrap.
   always_comb begin
      w_value_nxt = r_value;
      w_carry_nxt = 1'b0;
      w_ovf_set   = 1'b0;
      w_chain     = 1'b0;
      if (w_accept) begin
         w_value_nxt[3:0] = r_s2;
         if ((r_value[3:0] == 4'd9) && (r_s2 == 4'd0)) begin
            w_carry_nxt = 1'b1;
            w_chain     = 1'b1;
            for (int i = 1; i < DIGITS; i++) begin
               if (w_chain) begin
                  if (r_value[4*i +: 4] == 4'd9) begin
                     w_value_nxt[4*i +: 4] = 4'd0;
                  end else begin
                     w_value_nxt[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
                     w_chain               = 1'b0;
                  end
               end
            end
            // Chain still live means every upper decade rolled over.
            w_ovf_set = w_chain;
         end
      end
   end

   // Count state: stability counter, BCD value, carry pulse and sticky overflow.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_stab  <= '0;
         r_value <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_stab  <= w_stab_nxt;
         r_value <= w_value_nxt;
         r_carry <= w_carry_nxt;
         r_ovf   <= r_ovf | w_ovf_set;
      end
   end

   // Next scan index, its one-hot enable and the digit it selects from the current value.
   always_comb begin
      w_pre_tc = (r_pre == PRE_TC);
      if (w_pre_tc) begin
         w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
         w_idx_nxt = r_idx;
      end
      w_an_nxt    = '0;
      w_digit_sel = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_idx_nxt == IDX_W'(i)) begin
            w_an_nxt[i] = 1'b1;
            w_digit_sel = r_value[4*i +: 4];
         end
      end
   end

   // Scan prescaler, index and registered display drive; seg refreshes every cycle.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_pre <= '0;
         r_idx <= '0;
         r_an  <= DIGITS'(1);
         r_seg <= 7'h3F;
      end else begin
         r_pre <= w_pre_tc ? '0 : r_pre + PRE_W'(1);
         r_idx <= w_idx_nxt;
         r_an  <= w_an_nxt;
         r_seg <= f_glyph(w_digit_sel);
      end
   end

   assign value    = r_value;
   assign carry    = r_carry;
   assign overflow = r_ovf;
   assign seg      = r_seg;
   assign an       = r_an;

endmodule
